// File: rtl/plot_pkg.sv
// Shared types and geometry for the plot_graph front-end.
package plot_pkg;

    typedef logic [1:0] coord_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sched_state_e;

    localparam int unsigned PLOT_ROWS   = 4;
    localparam int unsigned PLOT_COLS   = 4;
    localparam int unsigned PLOT_PIXELS = PLOT_ROWS * PLOT_COLS;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, circular.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // One spare bit lets the wrap work for non-power-of-2 N.
            sum = {1'b0, ptr_i} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Round-robin, frame-paced sample scheduler and display-clear sequencer
// feeding the plot_graph engine.
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned RATE    = 1,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [2*NUM_REQ-1:0] req_coord_i,
    input  logic [NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 clear_i,
    input  logic                 frame_sync_i,
    output logic [1:0]           plotcoord_o,
    output logic                 plotdata_o,
    output logic                 newdata_o,
    output logic [ID_W-1:0]      owner_o,
    output logic                 busy_o
);

    localparam int unsigned FC_W    = $clog2(RATE + 1);
    localparam logic [0:0]  StIdle  = IDLE;
    localparam logic [0:0]  StClear = CLEAR;
    localparam logic [3:0]  ClrLast = 4'(PLOT_PIXELS - 1);

    logic [0:0]      state_q, state_d;
    logic [3:0]      clr_cnt_q, clr_cnt_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            token_q, token_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    coord_t          coord_q, coord_d;
    logic            data_q, data_d;
    logic            newdata_q, newdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               grant_en;
    logic               xfer;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx)
    );

    // clear_i suppresses any grant in the same cycle.
    assign grant_en    = (state_q == StIdle) && token_q && !clear_i;
    assign req_ready_o = grant_en ? gnt : '0;
    assign xfer        = |(req_valid_i & req_ready_o);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        frame_cnt_d = frame_cnt_q;
        token_d     = token_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        coord_d     = coord_q;
        data_d      = data_q;
        newdata_d   = 1'b0;

        if (frame_sync_i) begin
            if (frame_cnt_q == FC_W'(RATE - 1)) begin
                frame_cnt_d = '0;
                token_d     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (clear_i) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    newdata_d = 1'b1;
                    coord_d   = '0;
                    data_d    = 1'b0;
                end else if (xfer) begin
                    newdata_d = 1'b1;
                    coord_d   = req_coord_i[{gnt_idx, 1'b0} +: 2];
                    data_d    = req_data_i[gnt_idx];
                    owner_d   = gnt_idx;
                    token_d   = 1'b0;
                    rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                end
            end
            StClear: begin
                // Registered outputs run one step ahead so each write lines up
                // with the clr_cnt value shown while busy.
                if (clr_cnt_q == ClrLast) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                    newdata_d = 1'b1;
                    coord_d   = coord_t'(clr_cnt_d[3:2]);
                    data_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            clr_cnt_q   <= '0;
            frame_cnt_q <= '0;
            token_q     <= 1'b0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            coord_q     <= '0;
            data_q      <= 1'b0;
            newdata_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            token_q     <= token_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            coord_q     <= coord_d;
            data_q      <= data_d;
            newdata_q   <= newdata_d;
        end
    end

    assign plotcoord_o = coord_q;
    assign plotdata_o  = data_q;
    assign newdata_o   = newdata_q;
    assign owner_o     = owner_q;
    assign busy_o      = (state_q == StClear);

endmodule
